network_if_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream `network_if` stream between `NUM_IN` upstream `network_if` requesters, with optional burst locking and a registered output stage. It sits in front of a shared consumer, such as a copier FIFO, an aggregation unit or a memory port, wherever several producers feed one sink. `val` and `id` pass through unchanged, and the source index of every output beat is reported alongside.

---
 rtl/network_if_arbiter_pkg.sv | 47 ++++
 rtl/network_if_arbiter_if.sv | 23 ++
 rtl/network_if_arbiter_rr_arbiter.sv | 55 +++++
 rtl/network_if_arbiter.sv | 154 +++++++++++++++
 tb/tb_network_if_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/network_if_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// network_arb_pkg
//   Shared types and helpers for the network_if arbiter family.
//   - arb_state_t : grant FSM state (ARB = free round-robin, HOLD = burst lock)
//   - rr_pick     : one-hot round-robin scan over a request vector, starting
//                   at a given index and wrapping after index 'top'.
// -----------------------------------------------------------------------------
package network_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // rr_pick works on a fixed-width vector so one function serves every
  // requester count; callers zero-extend their requests and keep the low bits.
  // Supports up to PICK_MAX requesters.
  localparam int PICK_MAX   = 32;
  localparam int PICK_IDX_W = 5;

  // Returns a one-hot vector with the first set request found scanning
  // start, start+1, ..., top, 0, 1, ... The index wraps by compare-and-reset
  // against 'top' so non-power-of-two counts work.
  function automatic logic [PICK_MAX-1:0] rr_pick(
    input logic [PICK_MAX-1:0]   req,
    input logic [PICK_IDX_W-1:0] start,
    input logic [PICK_IDX_W-1:0] top
  );
    logic [PICK_MAX-1:0]   g;
    logic [PICK_IDX_W-1:0] idx;
    logic                  found;
    g     = '0;
    found = 1'b0;
    idx   = start;
    for (int i = 0; i < PICK_MAX; i++) begin
      if (i <= int'(top)) begin
        if (!found && req[idx]) begin
          g[idx] = 1'b1;
          found  = 1'b1;
        end
        idx = (idx == top) ? '0 : idx + 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/network_if_arbiter_if.sv
// -----------------------------------------------------------------------------
// network_if
//   Single-beat valid/ready stream carrying a data word and an id.
//   Handshake: a beat transfers on a rising clock edge where valid && ready.
//   The master raises valid with val/id; ready may depend combinationally on
//   valid. A beat the master has presented may be withdrawn before it
//   transfers (the arbiter tolerates requesters dropping valid).
//   Ports (per modport):
//     master : out valid, val[IN_WIDTH], id[ID_WIDTH]; in ready
//     slave  : in  valid, val[IN_WIDTH], id[ID_WIDTH]; out ready
// -----------------------------------------------------------------------------
interface network_if #(
  parameter int IN_WIDTH = 32,
  parameter int ID_WIDTH = 8
);
  logic                valid;
  logic                ready;
  logic [IN_WIDTH-1:0] val;
  logic [ID_WIDTH-1:0] id;

  modport master (output valid, output val, output id, input ready);
  modport slave  (input valid, input val, input id, output ready);
endinterface

// File: rtl/network_if_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin grant with an optional hold override.
//   Ports:
//     req[NUM_IN]      in   request vector
//     last             in   index granted most recently; scan starts at last+1
//     hold             in   a burst lock is active for 'holder'
//     holder           in   index owning the burst lock
//     grant[NUM_IN]    out  one-hot grant
//     grant_idx        out  encoded index of grant (0 when no grant)
//     grant_valid      out  some request was granted
//   NUM_IN must be between 2 and network_arb_pkg::PICK_MAX.
// -----------------------------------------------------------------------------
module rr_arbiter
  import network_arb_pkg::*;
#(
  parameter int NUM_IN = 4
) (
  input  logic [NUM_IN-1:0]         req,
  input  logic [$clog2(NUM_IN)-1:0] last,
  input  logic                      hold,
  input  logic [$clog2(NUM_IN)-1:0] holder,
  output logic [NUM_IN-1:0]         grant,
  output logic [$clog2(NUM_IN)-1:0] grant_idx,
  output logic                      grant_valid
);

  localparam int IDX_W = $clog2(NUM_IN);
  localparam logic [IDX_W-1:0] TOP = IDX_W'(NUM_IN - 1);

  logic [IDX_W-1:0]  start;
  logic [NUM_IN-1:0] rr_grant;

  always_comb begin
    // Wrap by comparison so the pointer never leaves 0..NUM_IN-1.
    start    = (last == TOP) ? '0 : last + 1'b1;
    rr_grant = NUM_IN'(rr_pick(PICK_MAX'(req), PICK_IDX_W'(start),
                               PICK_IDX_W'(TOP)));

    // A still-requesting holder wins; otherwise fall through to the scan
    // in the same cycle so a dropped holder costs no idle cycle.
    grant = rr_grant;
    if (hold && req[holder]) begin
      grant         = '0;
      grant[holder] = 1'b1;
    end

    grant_valid = |grant;
    grant_idx   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/network_if_arbiter.sv
// -----------------------------------------------------------------------------
// network_if_arbiter
//   Shares one downstream network_if stream among NUM_IN requesters using
//   round-robin arbitration with optional burst locking (up to MAX_BURST
//   consecutive beats per requester) and a single registered output stage.
//   Ports:
//     clk        in   clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     enable     in   low: accept no new beats (the output register drains)
//     in[NUM_IN] slave requester streams
//     out        master shared output stream
//     src_idx    out  requester index of the beat on out (valid with out.valid)
//     busy       out  out.valid or a burst lock is held
//     state_dbg  out  current grant FSM state
// -----------------------------------------------------------------------------
module network_if_arbiter
  import network_arb_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int MAX_BURST = 1,
  parameter int IN_WIDTH  = 32,
  parameter int ID_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  network_if.slave                  in [NUM_IN],
  network_if.master                 out,
  output logic [$clog2(NUM_IN)-1:0] src_idx,
  output logic                      busy,
  output arb_state_t                state_dbg
);

  localparam int IDX_W = $clog2(NUM_IN);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  // Interface unpacking into plain arrays.
  logic [NUM_IN-1:0]   req;
  logic [NUM_IN-1:0]   in_rdy;
  logic [IN_WIDTH-1:0] in_val [NUM_IN];
  logic [ID_WIDTH-1:0] in_id  [NUM_IN];

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
    assign req[gi]        = in[gi].valid;
    assign in_val[gi]     = in[gi].val;
    assign in_id[gi]      = in[gi].id;
    assign in[gi].ready   = in_rdy[gi];
  end

  // State
  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    holder_q, holder_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;

  logic                out_valid_q;
  logic [IN_WIDTH-1:0] val_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [IDX_W-1:0]    src_q;

  // Grant
  logic [NUM_IN-1:0]   grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_valid;
  logic                load;
  logic                xfer;

  rr_arbiter #(.NUM_IN(NUM_IN)) u_rr (
    .req         (req),
    .last        (last_q),
    .hold        (state_q == HOLD),
    .holder      (holder_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign load = enable && (!out_valid_q || out.ready);
  assign xfer = load && grant_valid;

  // rst_n gates ready so upstream sees it fall the moment reset asserts,
  // without waiting for a clock.
  assign in_rdy = (rst_n && load) ? grant : '0;

  // Grant FSM: next state
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    holder_d = holder_q;
    cnt_d    = cnt_q;
    cnt_inc  = '0;
    if (xfer) begin
      last_d  = grant_idx;
      cnt_inc = (state_q == HOLD && grant_idx == holder_q) ? cnt_q + 1'b1
                                                           : CNT_W'(1);
      if (cnt_inc < BURST_MAX) begin
        state_d  = HOLD;
        holder_d = grant_idx;
        cnt_d    = cnt_inc;
      end else begin
        state_d = ARB;
        cnt_d   = '0;
      end
    end else if (state_q == HOLD && (!enable || (load && !req[holder_q]))) begin
      // Holder went idle while we could have taken a beat, or arbitration
      // was paused: release the lock.
      state_d = ARB;
      cnt_d   = '0;
    end
  end

  // Grant FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB;
      last_q   <= IDX_W'(NUM_IN - 1);
      holder_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      holder_q <= holder_d;
      cnt_q    <= cnt_d;
    end
  end

  // Output register. A consumed beat is cleared even while enable is low,
  // so the stage drains rather than re-presenting an already accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      val_q       <= '0;
      id_q        <= '0;
      src_q       <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      val_q       <= in_val[grant_idx];
      id_q        <= in_id[grant_idx];
      src_q       <= grant_idx;
    end else if (out.ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out.valid = out_valid_q;
  assign out.val   = val_q;
  assign out.id    = id_q;
  assign src_idx   = src_q;
  assign busy      = out_valid_q || (state_q == HOLD);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_network_if_arbiter.sv
// -----------------------------------------------------------------------------
// tb_network_if_arbiter
//   Two arbiters (MAX_BURST=1 and MAX_BURST=3) share the same requester
//   stimulus; each has its own interfaces and reference model instance.
// -----------------------------------------------------------------------------
module tb_network_if_arbiter;
  import network_arb_pkg::*;

  localparam int N = 4;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Shared stimulus
  logic         enable = 1'b0;
  logic         ordy   = 1'b0;
  logic [N-1:0] vld    = '0;
  logic [31:0]  dval [N];
  logic [7:0]   did  [N];

  network_if #(.IN_WIDTH(32), .ID_WIDTH(8)) in_a [N] ();
  network_if #(.IN_WIDTH(32), .ID_WIDTH(8)) in_b [N] ();
  network_if #(.IN_WIDTH(32), .ID_WIDTH(8)) out_a ();
  network_if #(.IN_WIDTH(32), .ID_WIDTH(8)) out_b ();

  logic [N-1:0] rdy_a, rdy_b;
  logic [1:0]   src_a, src_b;
  logic         busy_a, busy_b;
  arb_state_t   st_a, st_b;

  for (genvar i = 0; i < N; i++) begin : g_drv
    assign in_a[i].valid = vld[i];
    assign in_a[i].val   = dval[i];
    assign in_a[i].id    = did[i];
    assign in_b[i].valid = vld[i];
    assign in_b[i].val   = dval[i];
    assign in_b[i].id    = did[i];
    assign rdy_a[i]      = in_a[i].ready;
    assign rdy_b[i]      = in_b[i].ready;
  end
  assign out_a.ready = ordy;
  assign out_b.ready = ordy;

  network_if_arbiter #(.NUM_IN(N), .MAX_BURST(1), .IN_WIDTH(32), .ID_WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in(in_a), .out(out_a),
    .src_idx(src_a), .busy(busy_a), .state_dbg(st_a)
  );

  network_if_arbiter #(.NUM_IN(N), .MAX_BURST(3), .IN_WIDTH(32), .ID_WIDTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in(in_b), .out(out_b),
    .src_idx(src_b), .busy(busy_b), .state_dbg(st_b)
  );

  // Reference model: per arbiter, the last winner, the current run length
  // of the locked owner, and the contents of the output register.
  int          mb      [2] = '{1, 3};
  int          m_last  [2];
  int          m_run   [2];
  int          m_owner [2];
  int          m_g     [2];
  int          m_src   [2];
  bit          m_lock  [2];
  bit          m_ov    [2];
  logic [31:0] m_val   [2];
  logic [7:0]  m_id    [2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_last[d]  = N - 1;
      m_run[d]   = 0;
      m_owner[d] = 0;
      m_lock[d]  = 1'b0;
      m_ov[d]    = 1'b0;
      m_val[d]   = '0;
      m_id[d]    = '0;
      m_src[d]   = 0;
    end
  endtask

  // Requester that should be granted this cycle, or -1.
  function automatic int exp_grant(int d);
    int j;
    if (!(enable && (!m_ov[d] || ordy))) return -1;
    if (m_lock[d] && vld[m_owner[d]]) return m_owner[d];
    for (int k = 1; k <= N; k++) begin
      j = (m_last[d] + k) % N;
      if (vld[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_edge(int d);
    int g;
    bit ld;
    g  = m_g[d];
    ld = enable && (!m_ov[d] || ordy);
    if (g >= 0) begin
      if (m_lock[d] && g == m_owner[d]) m_run[d]++;
      else m_run[d] = 1;
      m_owner[d] = g;
      m_last[d]  = g;
      m_lock[d]  = (m_run[d] < mb[d]);
      if (!m_lock[d]) m_run[d] = 0;
      m_ov[d]  = 1'b1;
      m_val[d] = dval[g];
      m_id[d]  = did[g];
      m_src[d] = g;
    end else begin
      if (m_lock[d] && (!enable || (ld && !vld[m_owner[d]]))) begin
        m_lock[d] = 1'b0;
        m_run[d]  = 0;
      end
      if (ordy) m_ov[d] = 1'b0;
    end
  endtask

  task automatic check_dut(int d);
    logic [N-1:0] er, r;
    logic         ov, bz;
    logic [31:0]  v;
    logic [7:0]   id;
    logic [1:0]   s;
    m_g[d] = exp_grant(d);
    er = '0;
    if (m_g[d] >= 0) er[m_g[d]] = 1'b1;
    r  = (d == 0) ? rdy_a       : rdy_b;
    ov = (d == 0) ? out_a.valid : out_b.valid;
    v  = (d == 0) ? out_a.val   : out_b.val;
    id = (d == 0) ? out_a.id    : out_b.id;
    s  = (d == 0) ? src_a       : src_b;
    bz = (d == 0) ? busy_a      : busy_b;
    chk($sformatf("dut%0d ready", d), 64'(r), 64'(er));
    chk($sformatf("dut%0d out_valid", d), 64'(ov), 64'(m_ov[d]));
    chk($sformatf("dut%0d busy", d), 64'(bz), 64'(m_ov[d] || m_lock[d]));
    if (m_ov[d]) begin
      chk($sformatf("dut%0d out_val", d), 64'(v), 64'(m_val[d]));
      chk($sformatf("dut%0d out_id", d), 64'(id), 64'(m_id[d]));
      chk($sformatf("dut%0d src_idx", d), 64'(s), 64'(m_src[d]));
    end
  endtask

  task automatic new_data();
    for (int i = 0; i < N; i++) begin
      dval[i] = $urandom;
      did[i]  = 8'($urandom_range(0, 255));
    end
  endtask

  // Called just after a falling edge with inputs set; checks, clocks the
  // model across the rising edge and returns at the next falling edge.
  task automatic step();
    #1;
    check_dut(0);
    check_dut(1);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  int la, lb;

  initial begin
    new_data();
    enable = 1'b1;
    vld    = 4'hF;
    ordy   = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    // Reset values, with requests pending to show ready is held off.
    chk("rst out_valid a", 64'(out_a.valid), 64'd0);
    chk("rst out_val a", 64'(out_a.val), 64'd0);
    chk("rst out_id a", 64'(out_a.id), 64'd0);
    chk("rst src_idx a", 64'(src_a), 64'd0);
    chk("rst busy a", 64'(busy_a), 64'd0);
    chk("rst ready a", 64'(rdy_a), 64'd0);
    chk("rst out_valid b", 64'(out_b.valid), 64'd0);
    chk("rst ready b", 64'(rdy_b), 64'd0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;

    // All requesters valid: per-beat rotation on a, bursts of 3 on b.
    for (int k = 0; k < 12; k++) begin
      new_data();
      step();
      chk("seq a valid", 64'(out_a.valid), 64'd1);
      chk("seq a src", 64'(src_a), 64'(k % 4));
      chk("seq b src", 64'(src_b), 64'((k / 3) % 4));
    end

    // Reset while the output holds a beat.
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid a", 64'(out_a.valid), 64'd0);
    chk("midrst out_valid b", 64'(out_b.valid), 64'd0);
    chk("midrst ready a", 64'(rdy_a), 64'd0);
    chk("midrst ready b", 64'(rdy_b), 64'd0);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    new_data();
    step();
    chk("post rst src a", 64'(src_a), 64'd0);
    chk("post rst src b", 64'(src_b), 64'd0);

    // Requesters 1 and 2 only.
    vld = 4'b0110;
    for (int k = 0; k < 9; k++) begin
      new_data();
      step();
      chk("pair a src", 64'(src_a), 64'((k % 2 == 0) ? 1 : 2));
      chk("pair b src", 64'(src_b), 64'(((k / 3) % 2 == 0) ? 1 : 2));
    end

    // Requester 1 drops mid-burst: grant moves to 2 with no bubble.
    do_reset();
    vld = 4'b0110;
    new_data(); step();
    new_data(); step();
    chk("drop b src1", 64'(src_b), 64'd1);
    chk("drop b state1", 64'(st_b), 64'(HOLD));
    vld = 4'b0100;
    new_data(); step();
    chk("drop b valid", 64'(out_b.valid), 64'd1);
    chk("drop b src2", 64'(src_b), 64'd2);
    chk("drop b cnt1", 64'(st_b), 64'(HOLD));
    new_data(); step();
    chk("drop b cnt2", 64'(st_b), 64'(HOLD));
    new_data(); step();
    chk("drop b cnt3", 64'(st_b), 64'(ARB));

    // Backpressure with a known beat pending.
    vld = '0;
    step();
    vld     = 4'b0001;
    dval[0] = 32'hA5;
    did[0]  = 8'h03;
    ordy    = 1'b0;
    step();
    vld = 4'hF;
    for (int k = 0; k < 5; k++) begin
      new_data();
      step();
      chk("bp a val", 64'(out_a.val), 64'hA5);
      chk("bp a id", 64'(out_a.id), 64'h3);
      chk("bp a valid", 64'(out_a.valid), 64'd1);
      chk("bp b val", 64'(out_b.val), 64'hA5);
      chk("bp ready a", 64'(rdy_a), 64'd0);
      chk("bp ready b", 64'(rdy_b), 64'd0);
    end
    ordy = 1'b1;
    vld  = '0;
    step();
    chk("bp accepted once a", 64'(out_a.valid), 64'd0);
    chk("bp accepted once b", 64'(out_b.valid), 64'd0);

    // Enable low for 4 cycles mid-stream.
    vld = 4'hF;
    for (int k = 0; k < 5; k++) begin
      new_data();
      step();
    end
    la = int'(src_a);
    lb = int'(src_b);
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      new_data();
      step();
      chk("en0 a drained", 64'(out_a.valid), 64'd0);
      chk("en0 b drained", 64'(out_b.valid), 64'd0);
      chk("en0 ready a", 64'(rdy_a), 64'd0);
      chk("en0 ready b", 64'(rdy_b), 64'd0);
    end
    enable = 1'b1;
    new_data();
    step();
    chk("reen a src", 64'(src_a), 64'((la + 1) % N));
    chk("reen b src", 64'(src_b), 64'((lb + 1) % N));

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      vld    = 4'($urandom_range(0, 15));
      ordy   = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 7) != 0);
      new_data();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
